uart_axi_tx: RTL and testbench
==============================

# uart_axi_tx

AXI4 slave UART transmitter with a parametrised TX FIFO, programmable baud divider and a real 8N1 serial output. It sits on the peripheral side of the AXI interconnect at the same attachment point as the simulation-print UART, and replaces the behavioural print with synthesisable serial output and readable status. It supports write and read bursts with fixed-address semantics and reports FIFO overflow through the write response.

## Interface
- FIFO_DEPTH, 16: TX FIFO entries, power of two, >= 2.
- DIV_WIDTH, 16: width of the baud divider register.
- DEFAULT_DIV, 16: divider reset value, cycles per serial bit.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- arid_i/araddr_i/arlen_i/arsize_i/arburst_i/arvalid_i  in  4/32/8/3/2/1  AXI4 read address; arsize_i and arburst_i ignored.
- arready_o  out  1  read address ready.
- rid_o/rdata_o/rresp_o/rlast_o/rvalid_o  out  4/32/2/1/1  read data channel.
- rready_i  in  1  read data ready.
- awid_i/awaddr_i/awlen_i/awsize_i/awburst_i/awvalid_i  in  4/32/8/3/2/1  write address; awsize_i and awburst_i ignored.
- awready_o  out  1  write address ready.
- wid_i/wdata_i/wstrb_i/wlast_i/wvalid_i  in  4/32/4/1/1  write data; wid_i ignored.
- wready_o  out  1  write data ready.
- bid_o/bresp_o/bvalid_o  out  4/2/1  write response.
- bready_i  in  1  write response ready.
- tx_o  out  1  serial output, idle high.

## Operation
- Register map, decoded on addr[3:2]:
  - 0x0 TXDATA: write-only; wdata[7:0] is pushed when wstrb[0]=1. Reads return 0.
  - 0x4 STATUS: read-only. bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bits[15:8] fifo_count.
  - 0x8 DIV: read/write, DIV_WIDTH bits, zero-extended on read. Writing 0 stores 1.
  - 0xC: reads return 0; writes are ignored with OKAY.
- Write FSM:
  - W_IDLE: awready_o=1. On an AW handshake, latch awid and the register select, clear the err flag, and go to W_DATA.
  - W_DATA: wready_o=1. Each beat acts on the latched register. A TXDATA beat with the FIFO full is dropped and sets err. The beat with wlast_i=1 moves to W_RESP.
  - W_RESP: bvalid_o=1, bid_o = latched id, bresp_o = err ? 2'b10 (SLVERR) : 2'b00. On bready_i, return to W_IDLE.
- Read FSM:
  - R_IDLE: arready_o=1. On an AR handshake, latch arid, the register and beat count arlen+1, and go to R_DATA.
  - R_DATA: rvalid_o=1, rdata_o = register sampled live each beat, rresp_o=00, rlast_o=1 on the final beat. Return to R_IDLE after the last handshake.
- Read and write FSMs are independent and may be active at the same time.
- TX engine states: T_IDLE, T_START, T_DATA, T_STOP.
  - When the FIFO is non-empty in T_IDLE: pop one byte, latch DIV into the bit timer, go to T_START.
  - tx_o is 0 in T_START, data LSB first over 8 bits in T_DATA, 1 in T_STOP.
  - Each state or bit lasts exactly DIV cycles.
  - tx_busy = (state != T_IDLE) | ~fifo_empty.
- Simultaneous FIFO push (W_DATA beat) and pop (T_IDLE): both occur, count unchanged. A push to a full FIFO is dropped even when a pop happens in the same cycle.
- A DIV change takes effect at the next frame start, never mid-frame.

## Timing
- Reset values: all valid and ready outputs 0 (FSMs in IDLE, so awready_o and arready_o are 1 on the first cycle after reset), tx_o=1, DIV=DEFAULT_DIV, FIFO empty, rdata_o=0, bresp_o=0, rlast_o=0.
- Asserting reset mid-frame drives tx_o high immediately, empties the FIFO and aborts any AXI transaction.
- Write handshake: AW handshake in cycle n, W beat accepted from n+1 (one beat per cycle), bvalid_o in the cycle after the wlast beat.
- Read latency: rvalid_o first rises one cycle after the AR handshake.
- A pushed byte into an empty FIFO with the engine idle: tx_o falls to the start bit 2 cycles after the W handshake.
- Frame length is 10×DIV cycles. Back-to-back bytes have no idle gap between frames.
- FIFO pointers wrap at FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH and is held in log2(FIFO_DEPTH)+1 bits.

## Test plan
- Reset, then write 0x55 to TXDATA with DIV=16 → BRESP OKAY; tx_o shows 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), 16 cycles each, 160 cycles total.
- Write DIV=4, read DIV → rdata 0x4. Write DIV=0, read → 0x1.
- Set a long DIV, then issue a 20-beat TXDATA burst (awlen=19, FIFO_DEPTH=16) → bresp 2'b10. Exactly 17 bytes are transmitted (one popped plus 16 queued); the rest are dropped.
- Read STATUS with arlen=2 → 3 beats, rlast only on the third. Count decrements between beats as the FIFO drains.
- Concurrent read of STATUS during a write burst → both complete; rid_o and bid_o match their respective request ids.
- Assert reset mid-frame → tx_o=1 at once; after release STATUS reads 0x02 (empty, not busy).

Source files
------------

// File: rtl/uart_axi_tx.sv
// AXI4 slave UART transmitter: TX FIFO, programmable baud divider and 8N1 serial output.
// Write and read channels run independently; STATUS and DIV are readable over AXI.
module uart_axi_tx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // read address
    input  logic [3:0]  arid_i,
    input  logic [31:0] araddr_i,
    input  logic [7:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    // read data
    output logic [3:0]  rid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    // write address
    input  logic [3:0]  awid_i,
    input  logic [31:0] awaddr_i,
    input  logic [7:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    // write data
    input  logic [3:0]  wid_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    // write response
    output logic [3:0]  bid_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    // serial
    output logic        tx_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] SEL_TXDATA = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_DIV    = 2'd2;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tstate_t;

    wstate_t r_wstate, w_wstate_next;
    rstate_t r_rstate, w_rstate_next;
    tstate_t r_tstate, w_tstate_next;

    logic [3:0]           r_bid;
    logic [1:0]           r_wsel;
    logic                 r_err;
    logic [3:0]           r_rid;
    logic [1:0]           r_rsel;
    logic [8:0]           r_rcnt;
    logic [DIV_WIDTH-1:0] r_div;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;

    logic [7:0]           r_shift;
    logic [2:0]           r_bitcnt;
    logic [DIV_WIDTH-1:0] r_timer;
    logic [DIV_WIDTH-1:0] r_bitdiv;

    logic        w_full, w_empty, w_busy;
    logic        w_wbeat, w_push_req, w_push, w_pop, w_bit_end;
    logic        w_aw_hs, w_ar_hs, w_r_hs;
    logic [31:0] w_status, w_div_ext, w_rmux;
    logic        w_unused;

    assign w_unused = ^{arsize_i, arburst_i, awsize_i, awburst_i, wid_i,
                        araddr_i[31:4], araddr_i[1:0], awaddr_i[31:4], awaddr_i[1:0],
                        wdata_i[31:8], wstrb_i[3:1]};

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_busy    = (r_tstate != T_IDLE) || !w_empty;
    assign w_aw_hs   = awready_o && awvalid_i;
    assign w_ar_hs   = arready_o && arvalid_i;
    assign w_r_hs    = rvalid_o && rready_i;
    assign w_wbeat   = (r_wstate == W_DATA) && wvalid_i;
    assign w_push_req = w_wbeat && (r_wsel == SEL_TXDATA) && wstrb_i[0];
    assign w_push    = w_push_req && !w_full;
    assign w_bit_end = (r_timer == '0);
    // A new byte is taken either from idle or straight out of a finishing stop bit, so frames abut.
    assign w_pop     = !w_empty && ((r_tstate == T_IDLE) || ((r_tstate == T_STOP) && w_bit_end));

    // ---------------- write channel ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_wstate <= W_IDLE;
        else       r_wstate <= w_wstate_next;
    end

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (awvalid_i)           w_wstate_next = W_DATA;
            W_DATA:  if (wvalid_i && wlast_i) w_wstate_next = W_RESP;
            W_RESP:  if (bready_i)            w_wstate_next = W_IDLE;
            default:                          w_wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready_o = (r_wstate == W_IDLE);
        wready_o  = (r_wstate == W_DATA);
        bvalid_o  = (r_wstate == W_RESP);
        bid_o     = r_bid;
        bresp_o   = (bvalid_o && r_err) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bid  <= '0;
            r_wsel <= '0;
            r_err  <= 1'b0;
        end else if (w_aw_hs) begin
            r_bid  <= awid_i;
            r_wsel <= awaddr_i[3:2];
            r_err  <= 1'b0;
        end else if (w_push_req && w_full) begin
            r_err  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div <= DIV_RST;
        end else if (w_wbeat && (r_wsel == SEL_DIV)) begin
            r_div <= (wdata_i[DIV_WIDTH-1:0] == '0) ? DIV_ONE : wdata_i[DIV_WIDTH-1:0];
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_rstate <= R_IDLE;
        else       r_rstate <= w_rstate_next;
    end

    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (arvalid_i)                      w_rstate_next = R_DATA;
            R_DATA:  if (rready_i && (r_rcnt == 9'd1))   w_rstate_next = R_IDLE;
            default:                                     w_rstate_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_status              = '0;
        w_status[0]           = w_full;
        w_status[1]           = w_empty;
        w_status[2]           = w_busy;
        w_status[8 +: CW]     = r_count;
        w_div_ext             = '0;
        w_div_ext[DIV_WIDTH-1:0] = r_div;
        case (r_rsel)
            SEL_STATUS: w_rmux = w_status;
            SEL_DIV:    w_rmux = w_div_ext;
            default:    w_rmux = '0;
        endcase
    end

    always_comb begin
        arready_o = (r_rstate == R_IDLE);
        rvalid_o  = (r_rstate == R_DATA);
        rlast_o   = rvalid_o && (r_rcnt == 9'd1);
        rid_o     = r_rid;
        rresp_o   = 2'b00;
        rdata_o   = rvalid_o ? w_rmux : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rid  <= '0;
            r_rsel <= '0;
            r_rcnt <= '0;
        end else if (w_ar_hs) begin
            r_rid  <= arid_i;
            r_rsel <= araddr_i[3:2];
            r_rcnt <= {1'b0, arlen_i} + 9'd1;
        end else if (w_r_hs) begin
            r_rcnt <= r_rcnt - 9'd1;
        end
    end

    // ---------------- TX FIFO ----------------
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= wdata_i[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- TX engine ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_tstate <= T_IDLE;
        else       r_tstate <= w_tstate_next;
    end

    always_comb begin
        w_tstate_next = r_tstate;
        case (r_tstate)
            T_IDLE:  if (!w_empty)                          w_tstate_next = T_START;
            T_START: if (w_bit_end)                         w_tstate_next = T_DATA;
            T_DATA:  if (w_bit_end && (r_bitcnt == 3'd7))   w_tstate_next = T_STOP;
            T_STOP:  if (w_bit_end) w_tstate_next = w_empty ? T_IDLE : T_START;
            default:                                        w_tstate_next = T_IDLE;
        endcase
    end

    always_comb begin
        case (r_tstate)
            T_START: tx_o = 1'b0;
            T_DATA:  tx_o = r_shift[0];
            default: tx_o = 1'b1;
        endcase
    end

    // The divider is captured per frame so DIV writes never disturb a frame in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_timer  <= '0;
            r_bitdiv <= DIV_RST;
        end else if (w_pop) begin
            r_shift  <= r_mem[r_rptr];
            r_bitcnt <= '0;
            r_bitdiv <= r_div;
            r_timer  <= r_div - DIV_ONE;
        end else if (r_tstate != T_IDLE) begin
            if (w_bit_end) begin
                r_timer <= r_bitdiv - DIV_ONE;
                if (r_tstate == T_DATA) begin
                    r_shift  <= r_shift >> 1;
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
            end else begin
                r_timer <= r_timer - DIV_ONE;
            end
        end
    end

endmodule

// File: tb/tb_uart_axi_tx.sv
// Self-checking bench for uart_axi_tx: AXI register access, serial frame decode against a
// byte scoreboard, overflow, status draining, concurrent channels and mid-frame reset.
module tb_uart_axi_tx;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  arid_i;
    logic [31:0] araddr_i;
    logic [7:0]  arlen_i;
    logic [2:0]  arsize_i;
    logic [1:0]  arburst_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [3:0]  rid_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        rvalid_o;
    logic        rready_i;
    logic [3:0]  awid_i;
    logic [31:0] awaddr_i;
    logic [7:0]  awlen_i;
    logic [2:0]  awsize_i;
    logic [1:0]  awburst_i;
    logic        awvalid_i;
    logic        awready_o;
    logic [3:0]  wid_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wlast_i;
    logic        wvalid_i;
    logic        wready_o;
    logic [3:0]  bid_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i;
    logic        tx_o;

    uart_axi_tx #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .DEFAULT_DIV(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
        .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
        .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .tx_o(tx_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         frame_starts[$];
    int         rx_count = 0;
    bit         mon_en = 1'b1;
    int         mon_div = 16;

    int          last_w_hs;
    logic [31:0] rd_data [256];
    logic        rd_last [256];
    logic [3:0]  rd_id   [256];
    int          rd_beats;
    int          rd_first_wait;

    logic [7:0] m_byte, m_exp;
    logic       m_start, m_stop;

    // Serial decoder: samples each bit at its centre and scores against the expected byte queue.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_i === 1'b0 && tx_o === 1'b0) begin
                frame_starts.push_back(cyc);
                repeat (mon_div / 2) @(negedge clk);
                m_start = tx_o;
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    m_byte[i] = tx_o;
                end
                repeat (mon_div) @(negedge clk);
                m_stop = tx_o;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame got=%02h", m_byte);
                end else begin
                    m_exp = exp_q.pop_front();
                    if (m_byte !== m_exp || m_start !== 1'b0 || m_stop !== 1'b1) begin
                        errors++;
                        $display("FAIL serial_frame got=%02h start=%b stop=%b expected=%02h start=0 stop=1",
                                 m_byte, m_start, m_stop, m_exp);
                    end
                end
                rx_count++;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [31:0] d0, output logic [1:0] resp, output logic [3:0] bid,
                             output int b_wait, output bit ok);
        int t;
        ok = 1'b1;
        awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = 3'd2; awburst_i = 2'b01;
        awvalid_i = 1'b1;
        t = 0;
        while (!awready_o && t < 100) begin @(negedge clk); t++; end
        if (!awready_o) ok = 1'b0;
        @(negedge clk);
        awvalid_i = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wid_i = id; wdata_i = d0 + 32'(i); wstrb_i = 4'hF;
            wlast_i = (i == int'(len)); wvalid_i = 1'b1;
            t = 0;
            while (!wready_o && t < 100) begin @(negedge clk); t++; end
            if (!wready_o) ok = 1'b0;
            last_w_hs = cyc;
            @(negedge clk);
        end
        wvalid_i = 1'b0; wlast_i = 1'b0; bready_i = 1'b1;
        b_wait = 0;
        while (!bvalid_o && b_wait < 100) begin @(negedge clk); b_wait++; end
        if (!bvalid_o) ok = 1'b0;
        resp = bresp_o; bid = bid_o;
        @(negedge clk);
        bready_i = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input int gap, output bit ok);
        int t;
        ok = 1'b1;
        arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = 3'd2; arburst_i = 2'b01;
        arvalid_i = 1'b1;
        t = 0;
        while (!arready_o && t < 100) begin @(negedge clk); t++; end
        if (!arready_o) ok = 1'b0;
        @(negedge clk);
        arvalid_i = 1'b0;
        rd_beats = 0;
        for (int b = 0; b <= int'(len); b++) begin
            rready_i = 1'b1;
            t = 0;
            while (!rvalid_o && t < 100) begin @(negedge clk); t++; end
            if (b == 0) rd_first_wait = t;
            if (!rvalid_o) ok = 1'b0;
            rd_data[b] = rdata_o; rd_last[b] = rlast_o; rd_id[b] = rid_o;
            rd_beats++;
            @(negedge clk);
            if (b < int'(len) && gap > 0) begin
                rready_i = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        rready_i = 1'b0;
    endtask

    task automatic wait_drain(input int limit, output bit ok);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < limit) begin @(negedge clk); t++; end
        ok = (exp_q.size() == 0);
        repeat (2 * mon_div) @(negedge clk);
    endtask

    logic [1:0] resp;
    logic [3:0] bid;
    int         bw;
    bit         ok, ok2;

    task automatic test_reset();
        rst_i = 1'b1;
        arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0;
        rready_i = 1'b0;
        awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
        wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready_o, arready_o, wready_o, bvalid_o, rvalid_o} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_handshake got aw/ar/w/b/r=%b expected=11000",
                     {awready_o, arready_o, wready_o, bvalid_o, rvalid_o});
        end
        checks++;
        if (tx_o !== 1'b1 || rdata_o !== 32'h0 || bresp_o !== 2'b00 || rlast_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got tx=%b rdata=%h bresp=%b rlast=%b expected tx=1 rdata=0 bresp=00 rlast=0",
                     tx_o, rdata_o, bresp_o, rlast_o);
        end
        axi_read(4'h1, 32'h4, 8'd0, 0, ok);
        checks++;
        if (!ok || rd_data[0] !== 32'h0000_0002) begin
            errors++;
            $display("FAIL reset_status got=%h expected=00000002", rd_data[0]);
        end
        axi_read(4'h1, 32'h8, 8'd0, 0, ok);
        checks++;
        if (!ok || rd_data[0] !== 32'd16) begin
            errors++;
            $display("FAIL reset_div got=%0d expected=16", rd_data[0]);
        end
    endtask

    task automatic test_frame();
        logic [9:0] pat;
        int         bad[10];
        int         hs;
        pat = {1'b1, 8'h55, 1'b0};
        mon_div = 16;
        exp_q.push_back(8'h55);
        axi_write(4'h3, 32'h0, 8'd0, 32'h55, resp, bid, bw, ok);
        checks++;
        if (!ok || resp !== 2'b00 || bid !== 4'h3) begin
            errors++;
            $display("FAIL frame_bresp got resp=%b bid=%h expected resp=00 bid=3", resp, bid);
        end
        checks++;
        if (bw !== 0) begin
            errors++;
            $display("FAIL frame_bvalid_latency got wait=%0d expected=0", bw);
        end
        hs = last_w_hs;
        checks++;
        if (cyc > hs + 2) begin
            errors++;
            $display("FAIL frame_sync got cycle=%0d expected<=%0d", cyc, hs + 2);
        end
        while (cyc < hs + 2) @(negedge clk);
        for (int s = 0; s < 10; s++) bad[s] = 0;
        for (int j = 0; j < 160; j++) begin
            if (tx_o !== pat[j / 16]) bad[j / 16]++;
            @(negedge clk);
        end
        for (int s = 0; s < 10; s++) begin
            checks++;
            if (bad[s] != 0) begin
                errors++;
                $display("FAIL frame_bit%0d got %0d wrong cycles of 16 expected level=%b", s, bad[s], pat[s]);
            end
        end
        checks++;
        if (tx_o !== 1'b1) begin
            errors++;
            $display("FAIL frame_idle_after got tx=%b expected=1", tx_o);
        end
        wait_drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL frame_drain got pending=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_div();
        axi_write(4'h2, 32'h8, 8'd0, 32'h4, resp, bid, bw, ok);
        axi_read(4'h6, 32'h8, 8'd0, 0, ok2);
        checks++;
        if (!ok || !ok2 || resp !== 2'b00 || rd_data[0] !== 32'h4) begin
            errors++;
            $display("FAIL div_write4 got rdata=%h resp=%b expected rdata=00000004 resp=00", rd_data[0], resp);
        end
        checks++;
        if (rd_first_wait !== 0 || rd_last[0] !== 1'b1 || rd_id[0] !== 4'h6) begin
            errors++;
            $display("FAIL read_timing got wait=%0d rlast=%b rid=%h expected wait=0 rlast=1 rid=6",
                     rd_first_wait, rd_last[0], rd_id[0]);
        end
        axi_write(4'h2, 32'h8, 8'd0, 32'h0, resp, bid, bw, ok);
        axi_read(4'h6, 32'h8, 8'd0, 0, ok2);
        checks++;
        if (!ok || !ok2 || rd_data[0] !== 32'h1) begin
            errors++;
            $display("FAIL div_write0 got=%h expected=00000001", rd_data[0]);
        end
        axi_read(4'h6, 32'h0, 8'd0, 0, ok2);
        checks++;
        if (!ok2 || rd_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL txdata_read got=%h expected=00000000", rd_data[0]);
        end
    endtask

    task automatic test_overflow();
        int rx0, badgap;
        axi_write(4'h2, 32'h8, 8'd0, 32'h4, resp, bid, bw, ok);
        mon_div = 4;
        frame_starts.delete();
        rx0 = rx_count;
        for (int i = 0; i < 17; i++) exp_q.push_back(8'hA0 + 8'(i));
        axi_write(4'h7, 32'h0, 8'd19, 32'hA0, resp, bid, bw, ok);
        checks++;
        if (!ok || resp !== 2'b10 || bid !== 4'h7) begin
            errors++;
            $display("FAIL overflow_bresp got resp=%b bid=%h expected resp=10 bid=7", resp, bid);
        end
        axi_read(4'h4, 32'h4, 8'd0, 0, ok);
        checks++;
        if (!ok || rd_data[0] !== 32'h0000_1005) begin
            errors++;
            $display("FAIL overflow_status got=%h expected=00001005", rd_data[0]);
        end
        wait_drain(17 * 40 + 200, ok);
        repeat (100) @(negedge clk);
        checks++;
        if (!ok || rx_count - rx0 != 17) begin
            errors++;
            $display("FAIL overflow_count got=%0d expected=17", rx_count - rx0);
        end
        badgap = 0;
        for (int k = 1; k < frame_starts.size(); k++)
            if (frame_starts[k] - frame_starts[k-1] != 40) badgap++;
        checks++;
        if (badgap != 0 || frame_starts.size() != 17) begin
            errors++;
            $display("FAIL back_to_back got frames=%0d bad_gaps=%0d expected frames=17 bad_gaps=0",
                     frame_starts.size(), badgap);
        end
    endtask

    task automatic test_status_drain();
        logic [7:0] c0, c1, c2;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h11 + 8'(i));
        axi_write(4'h1, 32'h0, 8'd3, 32'h11, resp, bid, bw, ok);
        axi_read(4'h2, 32'h4, 8'd2, 45, ok2);
        checks++;
        if (!ok2 || rd_beats != 3 || {rd_last[0], rd_last[1], rd_last[2]} !== 3'b001) begin
            errors++;
            $display("FAIL drain_rlast got beats=%0d rlast=%b%b%b expected beats=3 rlast=001",
                     rd_beats, rd_last[0], rd_last[1], rd_last[2]);
        end
        c0 = rd_data[0][15:8]; c1 = rd_data[1][15:8]; c2 = rd_data[2][15:8];
        checks++;
        if (!(c0 > c1 && c1 > c2 && c2 > 0)) begin
            errors++;
            $display("FAIL drain_count got=%0d,%0d,%0d expected strictly decreasing nonzero", c0, c1, c2);
        end
        checks++;
        if (rd_data[0][2] !== 1'b1 || rd_data[2][2] !== 1'b1 || rd_id[2] !== 4'h2) begin
            errors++;
            $display("FAIL drain_busy got busy=%b%b rid=%h expected busy=11 rid=2",
                     rd_data[0][2], rd_data[2][2], rd_id[2]);
        end
        wait_drain(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL drain_done got pending=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_concurrent();
        int badr;
        fork
            axi_write(4'h5, 32'hC, 8'd3, 32'h0, resp, bid, bw, ok);
            axi_read(4'h9, 32'h4, 8'd3, 0, ok2);
        join
        checks++;
        if (!ok || bid !== 4'h5 || resp !== 2'b00) begin
            errors++;
            $display("FAIL concurrent_write got bid=%h resp=%b expected bid=5 resp=00", bid, resp);
        end
        badr = 0;
        for (int b = 0; b < 4; b++)
            if (rd_id[b] !== 4'h9 || rd_data[b] !== 32'h2 || rd_last[b] !== (b == 3)) badr++;
        checks++;
        if (!ok2 || rd_beats != 4 || badr != 0) begin
            errors++;
            $display("FAIL concurrent_read got beats=%0d bad=%0d rid0=%h expected beats=4 bad=0 rid=9",
                     rd_beats, badr, rd_id[0]);
        end
        axi_read(4'h3, 32'hC, 8'd0, 0, ok2);
        checks++;
        if (!ok2 || rd_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL reg_c_read got=%h expected=00000000", rd_data[0]);
        end
    endtask

    task automatic test_reset_midframe();
        int t, hi_bad;
        axi_write(4'h2, 32'h8, 8'd0, 32'd16, resp, bid, bw, ok);
        mon_div = 16;
        mon_en = 1'b0;
        axi_write(4'h1, 32'h0, 8'd2, 32'h0, resp, bid, bw, ok);
        t = 0;
        while (tx_o !== 1'b0 && t < 50) begin @(negedge clk); t++; end
        repeat (20) @(negedge clk);
        checks++;
        if (tx_o !== 1'b0) begin
            errors++;
            $display("FAIL midframe_low got tx=%b expected=0", tx_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (tx_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx_immediate got tx=%b expected=1", tx_o);
        end
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready_o, arready_o, bvalid_o, rvalid_o} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_abort got aw/ar/b/r=%b expected=1100", {awready_o, arready_o, bvalid_o, rvalid_o});
        end
        hi_bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx_o !== 1'b1) hi_bad++;
            @(negedge clk);
        end
        checks++;
        if (hi_bad != 0) begin
            errors++;
            $display("FAIL reset_tx_idle got %0d low cycles expected=0", hi_bad);
        end
        axi_read(4'h1, 32'h4, 8'd0, 0, ok);
        checks++;
        if (!ok || rd_data[0] !== 32'h0000_0002) begin
            errors++;
            $display("FAIL reset_midframe_status got=%h expected=00000002", rd_data[0]);
        end
        mon_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_div();
        test_overflow();
        test_status_drain();
        test_concurrent();
        test_reset_midframe();
        repeat (20) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
